// File: rtl/mrmac_0_axil_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// mrmac_0_axil_cfg_arbiter
//
// Shares the single 32-bit AXI4-Lite configuration port of the MRMAC
// example design between NUM_REQ register-access requesters. Requesters
// are picked round-robin. Each grant runs exactly one AXI4-Lite read or
// write, and the response is handed back to the requester that owns it.
//
// Optional feature macro: MRMAC_CFG_TIMEOUT_EN
//   When defined, a transfer that sees no slave handshake for
//   TIMEOUT_CYCLES cycles is abandoned. It completes with resp 2'b11.
//   When undefined, the arbiter waits for the slave indefinitely.
//
// Ports
//   s_axi_aclk, s_axi_areset   config clock, async active-high reset
//   req_valid[NUM_REQ]         command pending, held until req_done
//   req_we[NUM_REQ]            1 = write, 0 = read
//   req_addr/req_wdata         32 bits per requester, slice i = [32i+31:32i]
//   req_done[NUM_REQ]          one-hot, one-cycle completion pulse
//   req_rdata, req_resp        read data / AXI response, valid with req_done
//   busy                       a transaction is in flight
//   m_axi_*                    AXI4-Lite master, 32-bit addr/data
// ---------------------------------------------------------------------------
module mrmac_0_axil_cfg_arbiter #(
  parameter int NUM_REQ = 4
`ifdef MRMAC_CFG_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [31:0]           req_rdata,
  output logic [1:0]            req_resp,
  output logic                  busy,
  output logic [31:0]           m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [31:0]           m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD,
    RD_RESP
  } state_t;

  state_t        state;
  state_t        next_state;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant;
  logic [PW-1:0] pick;
  logic [PW-1:0] ptr_next;
  logic          pick_found;
  logic          grant_now;
  logic          start;
  logic          aw_done;
  logic          w_done;
  logic          aw_hs;
  logic          w_hs;
  logic          b_hs;
  logic          ar_hs;
  logic          r_hs;
  logic          any_hs;
  logic          aw_fin;
  logic          w_fin;
  logic          abort;
  logic          fin_now;
  logic [1:0]    fin_resp;
  logic [31:0]   fin_rdata;

  assign aw_hs  = m_axi_awvalid && m_axi_awready;
  assign w_hs   = m_axi_wvalid && m_axi_wready;
  assign b_hs   = m_axi_bvalid && m_axi_bready;
  assign ar_hs  = m_axi_arvalid && m_axi_arready;
  assign r_hs   = m_axi_rvalid && m_axi_rready;
  assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || w_hs;

  assign m_axi_wstrb  = 4'hF;
  assign m_axi_bready = (state == WR_RESP);
  assign m_axi_rready = (state == RD_RESP);
  assign busy         = (state != IDLE);

  // The pointer advances past the requester that was just served. This
  // guarantees that every requester waits at most NUM_REQ-1 transactions.
  assign ptr_next = (grant == PW'(NUM_REQ - 1)) ? '0 : grant + PW'(1);

  // Round-robin search. Start at the pointer and walk upward, wrapping
  // modulo NUM_REQ. The first pending requester wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = '0;
    pick_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick       = PW'(idx);
      end
    end
  end

  // No grant is made in the cycle where req_done is pulsing. The
  // requester that just finished may still show req_valid in that cycle.
  // This masked cycle is the one-cycle gap between transactions.
  assign grant_now = pick_found && (req_done == '0);

`ifdef MRMAC_CFG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Watchdog for a stalled slave. It counts cycles spent in any busy state
  // and restarts on every handshake. It fires on the last cycle of the
  // window, so the transfer is abandoned at that cycle's edge.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      to_cnt <= '0;
    end else if ((state == IDLE) || any_hs) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  assign abort = (state != IDLE) && !any_hs && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A write leaves WR only after both the AW and the W
  // beats have been accepted, in whichever order the slave takes them.
  // An abort overrides every other transition.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_now) next_state = req_we[pick] ? WR : RD;
      WR:      if (!start && aw_fin && w_fin) next_state = WR_RESP;
      WR_RESP: if (m_axi_bvalid) next_state = IDLE;
      RD:      if (ar_hs) next_state = RD_RESP;
      RD_RESP: if (m_axi_rvalid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  // Completion decode. This covers the B or R handshake and the timeout
  // abort. Reads return the slave data. Writes and aborts return zero data.
  always_comb begin
    fin_now   = 1'b0;
    fin_resp  = 2'b00;
    fin_rdata = '0;
    if (abort) begin
      fin_now  = 1'b1;
      fin_resp = 2'b11;
    end else if (b_hs) begin
      fin_now  = 1'b1;
      fin_resp = m_axi_bresp;
    end else if (r_hs) begin
      fin_now   = 1'b1;
      fin_resp  = m_axi_rresp;
      fin_rdata = m_axi_rdata;
    end
  end

  // Datapath and AXI channel valids. The grant cycle latches the command.
  // The first cycle of WR or RD ('start') raises the address/data valids.
  // Each valid drops on its own handshake. req_done is registered, so it
  // pulses on the cycle after the B/R handshake.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      rr_ptr        <= '0;
      grant         <= '0;
      start         <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_araddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      req_done      <= '0;
      req_rdata     <= '0;
      req_resp      <= 2'b00;
    end else begin
      start <= 1'b0;
      if ((state == IDLE) && grant_now) begin
        grant   <= pick;
        start   <= 1'b1;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (req_we[pick]) begin
          m_axi_awaddr <= req_addr[32*pick +: 32];
          m_axi_wdata  <= req_wdata[32*pick +: 32];
        end else begin
          m_axi_araddr <= req_addr[32*pick +: 32];
        end
      end

      if ((state == WR) && start) begin
        m_axi_awvalid <= 1'b1;
        m_axi_wvalid  <= 1'b1;
      end
      if (aw_hs) begin
        m_axi_awvalid <= 1'b0;
        aw_done       <= 1'b1;
      end
      if (w_hs) begin
        m_axi_wvalid <= 1'b0;
        w_done       <= 1'b1;
      end

      if ((state == RD) && start) begin
        m_axi_arvalid <= 1'b1;
      end
      if (ar_hs) begin
        m_axi_arvalid <= 1'b0;
      end

      if (abort) begin
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_arvalid <= 1'b0;
      end

      req_done <= '0;
      if (fin_now) begin
        req_done  <= NUM_REQ'(1) << grant;
        req_rdata <= fin_rdata;
        req_resp  <= fin_resp;
        rr_ptr    <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_mrmac_0_axil_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mrmac_0_axil_cfg_arbiter
//
// Directed bench for the AXI4-Lite config arbiter. A small behavioural
// AXI4-Lite slave has adjustable ready delays and response stall knobs.
// It also records every accepted beat, so the bench can compare the
// traffic against hand-computed values.
// ---------------------------------------------------------------------------
module tb_mrmac_0_axil_cfg_arbiter;

  localparam int NUM_REQ = 4;
`ifdef MRMAC_CFG_TIMEOUT_EN
  localparam int TOUT = 16;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_done;
  logic [31:0]           req_rdata;
  logic [1:0]            req_resp;
  logic                  busy;
  logic [31:0]           m_axi_awaddr;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [31:0]           m_axi_wdata;
  logic [3:0]            m_axi_wstrb;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;
  logic [31:0]           m_axi_araddr;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [31:0]           m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  always #5 clk = ~clk;

  mrmac_0_axil_cfg_arbiter #(
    .NUM_REQ(NUM_REQ)
`ifdef MRMAC_CFG_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TOUT)
`endif
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_done     (req_done),
    .req_rdata    (req_rdata),
    .req_resp     (req_resp),
    .busy         (busy),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wstrb  (m_axi_wstrb),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready)
  );

  // Slave knobs, driven by the stimulus sequence
  int          aw_delay = 0;
  int          w_delay  = 0;
  logic        ar_block = 1'b0;
  logic        r_hold   = 1'b0;
  logic [1:0]  bresp_val = 2'b00;
  logic [1:0]  rresp_val = 2'b00;
  logic [31:0] rdata_val = 32'h0;

  // Slave protocol state
  int   aw_cnt;
  int   w_cnt;
  logic aw_got;
  logic w_got;
  logic r_pend;

  // Cumulative traffic statistics. Tests use before/after differences.
  int          aw_beats = 0;
  int          w_beats  = 0;
  int          b_beats  = 0;
  int          awv_cycles = 0;
  int          wv_cycles  = 0;
  int          busy_cycles = 0;
  logic [31:0] last_awaddr = 32'h0;
  logic [31:0] last_wdata  = 32'h0;
  logic [31:0] last_araddr = 32'h0;
  logic [3:0]  last_wstrb  = 4'h0;

  // Bench bookkeeping
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;
  logic [31:0] done_rdata;
  logic [1:0]  done_resp;
  int          lat;
  int          snap_a;
  int          snap_b;
  int          snap_c;

  // Ready generation. A channel becomes ready once its valid has waited
  // for the configured number of cycles. A delay of zero makes it ready at once.
  always_comb begin
    m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_delay);
    m_axi_wready  = m_axi_wvalid && (w_cnt >= w_delay);
    m_axi_arready = m_axi_arvalid && !ar_block;
  end

  // Slave response engine. B is raised the cycle after both AW and W have
  // been taken. R is raised the cycle after AR unless r_hold stalls it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt       <= 0;
      w_cnt        <= 0;
      aw_got       <= 1'b0;
      w_got        <= 1'b0;
      r_pend       <= 1'b0;
      m_axi_bvalid <= 1'b0;
      m_axi_bresp  <= 2'b00;
      m_axi_rvalid <= 1'b0;
      m_axi_rdata  <= 32'h0;
      m_axi_rresp  <= 2'b00;
    end else begin
      if (m_axi_awvalid && m_axi_awready) aw_cnt <= 0;
      else if (m_axi_awvalid) aw_cnt <= aw_cnt + 1;
      if (m_axi_wvalid && m_axi_wready) w_cnt <= 0;
      else if (m_axi_wvalid) w_cnt <= w_cnt + 1;

      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if ((aw_got || (m_axi_awvalid && m_axi_awready)) &&
          (w_got || (m_axi_wvalid && m_axi_wready))) begin
        m_axi_bvalid <= 1'b1;
        m_axi_bresp  <= bresp_val;
        aw_got       <= 1'b0;
        w_got        <= 1'b0;
      end else begin
        if (m_axi_awvalid && m_axi_awready) aw_got <= 1'b1;
        if (m_axi_wvalid && m_axi_wready) w_got <= 1'b1;
      end

      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
      if (((m_axi_arvalid && m_axi_arready) || r_pend) && !r_hold) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= rdata_val;
        m_axi_rresp  <= rresp_val;
        r_pend       <= 1'b0;
      end else if (m_axi_arvalid && m_axi_arready) begin
        r_pend <= 1'b1;
      end
    end
  end

  // Traffic recorder. It counts beats and valid-high cycles and keeps the
  // payload of the most recent beat on each channel.
  always @(posedge clk) begin
    if (m_axi_awvalid && m_axi_awready) begin
      aw_beats    <= aw_beats + 1;
      last_awaddr <= m_axi_awaddr;
    end
    if (m_axi_wvalid && m_axi_wready) begin
      w_beats    <= w_beats + 1;
      last_wdata <= m_axi_wdata;
      last_wstrb <= m_axi_wstrb;
    end
    if (m_axi_bvalid && m_axi_bready) b_beats <= b_beats + 1;
    if (m_axi_arvalid && m_axi_arready) last_araddr <= m_axi_araddr;
    if (m_axi_awvalid) awv_cycles <= awv_cycles + 1;
    if (m_axi_wvalid) wv_cycles <= wv_cycles + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
  end

  // Single comparison point. Counts it and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Raise one requester's command
  task automatic applyStimulus(input int idx, input logic we,
                               input logic [31:0] addr, input logic [31:0] wd);
    req_we[idx]              = we;
    req_addr[idx*32 +: 32]   = addr;
    req_wdata[idx*32 +: 32]  = wd;
    req_valid[idx]           = 1'b1;
  endtask

  // Wait (bounded) for a completion pulse and check that it goes to the
  // expected requester. Capture the returned data and drop that requester's valid.
  task automatic waitDone(input string tag, input int idx, input int budget,
                          output int cycles);
    logic        found;
    logic [31:0] onehot;
    found  = 1'b0;
    cycles = 0;
    onehot = 32'h1 << idx;
    while (!found && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (req_done != '0) found = 1'b1;
    end
    checkOutput(tag, 32'(req_done), onehot);
    done_rdata = req_rdata;
    done_resp  = req_resp;
    if (found) req_valid[idx] = 1'b0;
  endtask

  // Hard stop in case something wedges outside the bounded waits
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence
  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(req_done), 32'h0);
    checkOutput("rst_valids", {29'h0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 32'h0);
    checkOutput("rst_readies", {30'h0, m_axi_bready, m_axi_rready}, 32'h0);
    checkOutput("rst_awaddr", m_axi_awaddr, 32'h0);
    checkOutput("rst_wstrb", 32'(m_axi_wstrb), 32'hF);
    checkOutput("rst_rdata_resp", req_rdata | 32'(req_resp), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single write");
    snap_a = aw_beats;
    snap_b = b_beats;
    applyStimulus(0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF);
    waitDone("wr_done", 0, 20, lat);
    checkOutput("wr_latency", 32'(lat), 32'd4);
    checkOutput("wr_resp", 32'(done_resp), 32'h0);
    checkOutput("wr_rdata", done_rdata, 32'h0);
    checkOutput("wr_awaddr", last_awaddr, 32'h0000_0004);
    checkOutput("wr_wdata", last_wdata, 32'hDEAD_BEEF);
    checkOutput("wr_wstrb", 32'(last_wstrb), 32'hF);
    checkOutput("wr_aw_beats", 32'(aw_beats - snap_a), 32'd1);
    checkOutput("wr_b_beats", 32'(b_beats - snap_b), 32'd1);
    @(negedge clk);

    $display("[TB] single read");
    rdata_val = 32'h1234_5678;
    applyStimulus(2, 1'b0, 32'h0000_0100, 32'h0);
    waitDone("rd_done", 2, 20, lat);
    checkOutput("rd_latency", 32'(lat), 32'd4);
    checkOutput("rd_rdata", done_rdata, 32'h1234_5678);
    checkOutput("rd_resp", 32'(done_resp), 32'h0);
    checkOutput("rd_araddr", last_araddr, 32'h0000_0100);

    $display("[TB] contention from reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1'b0, 32'h200 + 32'(4 * i), 32'h0);
    for (int i = 0; i < NUM_REQ; i++) begin
      waitDone("rr_order", i, 20, lat);
      checkOutput("rr_araddr", last_araddr, 32'h200 + 32'(4 * i));
    end
    @(negedge clk);
    applyStimulus(1, 1'b0, 32'h0000_0310, 32'h0);
    applyStimulus(3, 1'b0, 32'h0000_0330, 32'h0);
    waitDone("rr_wrap_first", 1, 20, lat);
    checkOutput("rr_wrap_first_addr", last_araddr, 32'h0000_0310);
    waitDone("rr_wrap_second", 3, 20, lat);
    checkOutput("rr_wrap_second_addr", last_araddr, 32'h0000_0330);

    $display("[TB] split write handshake");
    @(negedge clk);
    aw_delay  = 5;
    bresp_val = 2'b10;
    snap_a = awv_cycles;
    snap_b = wv_cycles;
    snap_c = b_beats;
    applyStimulus(1, 1'b1, 32'h0000_0008, 32'hA5A5_0001);
    waitDone("split_done", 1, 40, lat);
    checkOutput("split_awvalid_cycles", 32'(awv_cycles - snap_a), 32'd6);
    checkOutput("split_wvalid_cycles", 32'(wv_cycles - snap_b), 32'd1);
    checkOutput("split_resp", 32'(done_resp), 32'h2);
    checkOutput("split_wdata", last_wdata, 32'hA5A5_0001);
    repeat (3) @(negedge clk);
    checkOutput("split_b_beats", 32'(b_beats - snap_c), 32'd1);
    aw_delay  = 0;
    bresp_val = 2'b00;

    $display("[TB] reset during read response");
    r_hold = 1'b1;
    applyStimulus(3, 1'b0, 32'h0000_0300, 32'h0);
    lat = 0;
    while (!m_axi_rready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("mid_rd_resp_state", 32'(m_axi_rready), 32'h1);
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    checkOutput("mid_rst_busy", 32'(busy), 32'h0);
    checkOutput("mid_rst_done", 32'(req_done), 32'h0);
    checkOutput("mid_rst_handshake", {30'h0, m_axi_rready, m_axi_arvalid}, 32'h0);
    checkOutput("mid_rst_araddr", m_axi_araddr, 32'h0);
    checkOutput("mid_rst_resp", 32'(req_resp), 32'h0);
    rst    = 1'b0;
    r_hold = 1'b0;
    @(negedge clk);
    applyStimulus(2, 1'b0, 32'h0000_0120, 32'h0);
    applyStimulus(0, 1'b0, 32'h0000_0100, 32'h0);
    waitDone("post_rst_first", 0, 20, lat);
    waitDone("post_rst_second", 2, 20, lat);
    checkOutput("post_rst_araddr", last_araddr, 32'h0000_0120);

`ifdef MRMAC_CFG_TIMEOUT_EN
    $display("[TB] read timeout");
    @(negedge clk);
    ar_block = 1'b1;
    snap_a   = busy_cycles;
    applyStimulus(1, 1'b0, 32'h0000_0040, 32'h0);
    applyStimulus(2, 1'b0, 32'h0000_0044, 32'h0);
    waitDone("to_done", 1, 60, lat);
    checkOutput("to_resp", 32'(done_resp), 32'h3);
    checkOutput("to_rdata", done_rdata, 32'h0);
    checkOutput("to_arvalid", 32'(m_axi_arvalid), 32'h0);
    checkOutput("to_busy_cycles", 32'(busy_cycles - snap_a), 32'(TOUT));
    ar_block = 1'b0;
    waitDone("to_next", 2, 20, lat);
    checkOutput("to_next_resp", 32'(done_resp), 32'h0);
    checkOutput("to_next_araddr", last_araddr, 32'h0000_0044);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
